data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2: cycles from request-accept edge to d_data_valid high; at least 1.
REQ-003 clk input 1: clock; all state updates on its rising edge.
REQ-004 reset input 1: asynchronous, active-high reset.
REQ-005 req input 1: level request from the control unit; held high until d_data_valid is seen.
REQ-006 mem_write input 1: 1 = store, 0 = load; sampled at accept.
REQ-007 funct3 input 3: access width/sign code; sampled at accept.
REQ-008 addr input 32: byte address; sampled at accept.
REQ-009 wdata input 32: store data, right-aligned; sampled at accept.
REQ-010 rdata output 32: load result, extended to 32 bits.
REQ-011 d_data_valid output 1: one-cycle completion pulse.
REQ-012 busy output 1: high whenever state is not IDLE.
REQ-013 err output 1: misalignment flag; exists only under DMEM_MISALIGN_ERR_EN.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP and DRAIN.
REQ-015 IDLE with req=1 SHALL accept: latch addr, wdata, funct3 and mem_write, and load countdown with LATENCY-1.
- Next state is RESP if LATENCY=1, else WAIT.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
- Net effect: d_data_valid rises exactly LATENCY cycles after the accept edge.
REQ-017 RESP SHALL assert d_data_valid for exactly one cycle.
- Next state is DRAIN if req=1, else IDLE.
REQ-018 DRAIN SHALL hold until req=0, then go to IDLE.
- No new accept while req stays high after a completion.
REQ-019 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
- Higher address bits are ignored, so accesses wrap modulo the array size.
REQ-020 Store writes SHALL commit on the clock edge ending RESP, using byte enables:
- SB (000): lane addr[1:0], data wdata[7:0].
- SH (001): lanes {2*addr[1], 2*addr[1]+1}, data wdata[15:0].
- SW (010): all four lanes.
- Any other funct3: no write; d_data_valid still pulses.
REQ-021 Load data SHALL come from the latched word, valid during RESP:
- LB (000), LH (001): sign-extended.
- LW (010): full word.
- LBU (100), LHU (101): zero-extended.
- Other funct3: rdata = 0.
REQ-022 rdata SHALL be 0 whenever d_data_valid=0, and 0 during a store's RESP.
REQ-023 Load in RESP SHALL return array contents as of accept time plus all earlier committed writes; back-to-back store-then-load to the same address returns the stored data.
REQ-024 busy SHALL be combinational from state: 0 in IDLE, 1 in WAIT, RESP and DRAIN.

Reset
REQ-025 reset high SHALL force: state IDLE, counter 0, d_data_valid 0, rdata 0, busy 0, err 0, latched request fields 0.
REQ-026 reset mid-operation SHALL drop the pending access: no write commits and no d_data_valid is issued.
- Storage array contents are not cleared by reset.
REQ-027 After reset deassertion with req already high, an accept SHALL occur on the first rising edge.

Configuration
REQ-028 Macro DMEM_MISALIGN_ERR_EN gates misalignment checking.
REQ-029 Macro defined: an access is misaligned if
- LH/LHU/SH with addr[0]=1, or
- LW/SW with addr[1:0]≠0.
Then err pulses together with d_data_valid, the write is suppressed, and rdata = 0.
REQ-030 Macro undefined: no err port.
- Misaligned low address bits are truncated: halfword uses addr[1]; word ignores addr[1:0].
- The access proceeds normally.

Verification
REQ-031 Reset, LATENCY=2; SW addr=0x10 wdata=0xDEADBEEF; req held high → d_data_valid pulses 2 cycles after accept; FSM reaches DRAIN; busy stays high until req drops.
REQ-032 After REQ-031: LB addr=0x13 → rdata=0xFFFFFFDE; LBU addr=0x13 → 0x000000DE; LH addr=0x10 → 0xFFFFBEEF; LW addr=0x10 → 0xDEADBEEF.
REQ-033 SB addr=0x11 wdata=0x55, then LW addr=0x10 → 0xDEAD55EF; LW addr=0x10+4*DEPTH_WORDS → same value (wrap).
REQ-034 Assert reset during WAIT of SW addr=0x20 wdata=0x12345678 → no d_data_valid pulse; subsequent LW addr=0x20 returns the prior contents.
REQ-035 With DMEM_MISALIGN_ERR_EN: SW addr=0x22 wdata=0xFFFFFFFF → err=1 with d_data_valid and word 0x20 unchanged. Without the macro, the same access writes word 0x20 = 0xFFFFFFFF.
REQ-036 LATENCY=1; req pulsed high for one cycle with funct3=011 load → d_data_valid on the next cycle with rdata=0; FSM returns to IDLE with no DRAIN.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder; define DMEM_MISALIGN_ERR_EN to add misalignment checking and the err output
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        d_data_valid,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic        err,
`endif
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [AW+1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic [2:0]     r_funct3;
    logic           r_mem_write;
    logic [31:0]    r_rdata;
    logic           r_valid;
`ifdef DMEM_MISALIGN_ERR_EN
    logic           r_err;
`endif
    logic [31:0]    r_mem [0:DEPTH_WORDS-1];

    logic [AW-1:0]  w_idx;
    logic [3:0]     w_be;
    logic [31:0]    w_wd;
    logic           w_unused_addr_hi;

    // Address bits above the array are ignored so accesses wrap.
    assign w_unused_addr_hi = ^addr[31:AW+2];
    assign w_idx            = r_addr[AW+1:2];

    // Halfword needs even address, word needs 4-byte alignment.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic we, input logic [1:0] lo);
        return ((f3 == 3'b001) && lo[0]) ||
               ((f3 == 3'b101) && !we && lo[0]) ||
               ((f3 == 3'b010) && (lo != 2'b00));
    endfunction

    // Extract and extend the load result; stores and flagged accesses return zero.
    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lo, input logic we);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = 32'h0;
        endcase
        if (we || (MIS_EN && f_misaligned(f3, we, lo))) begin
            res = 32'h0;
        end
        return res;
    endfunction

    // Byte enables and lane-replicated store data from the latched request.
    always_comb begin
        w_be = 4'b0000;
        w_wd = 32'h0;
        case (r_funct3)
            3'b000: begin
                w_be = 4'b0001 << r_addr[1:0];
                w_wd = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_be = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{r_wdata[15:0]}};
            end
            3'b010: begin
                w_be = 4'b1111;
                w_wd = r_wdata;
            end
            default: ;
        endcase
        if (!r_mem_write || (MIS_EN && f_misaligned(r_funct3, r_mem_write, r_addr[1:0]))) begin
            w_be = 4'b0000;
        end
    end

    // Store commits on the edge that ends RESP; reset leaves the array untouched.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered completion pulse, load data and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_funct3    <= 3'b000;
            r_mem_write <= 1'b0;
            r_rdata     <= 32'h0;
            r_valid     <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_rdata <= 32'h0;
`ifdef DMEM_MISALIGN_ERR_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr      <= addr[AW+1:0];
                        r_wdata     <= wdata;
                        r_funct3    <= funct3;
                        r_mem_write <= mem_write;
                        r_cnt       <= CNT_INIT;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_valid <= 1'b1;
                            r_rdata <= f_load(r_mem[addr[AW+1:2]], funct3, addr[1:0], mem_write);
`ifdef DMEM_MISALIGN_ERR_EN
                            r_err   <= f_misaligned(funct3, mem_write, addr[1:0]);
`endif
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_RESP;
                        r_valid <= 1'b1;
                        r_rdata <= f_load(r_mem[w_idx], r_funct3, r_addr[1:0], r_mem_write);
`ifdef DMEM_MISALIGN_ERR_EN
                        r_err   <= f_misaligned(r_funct3, r_mem_write, r_addr[1:0]);
`endif
                    end
                end
                S_RESP: begin
                    r_state <= req ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (!req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata        = r_rdata;
    assign d_data_valid = r_valid;
    assign busy         = (r_state != S_IDLE);
`ifdef DMEM_MISALIGN_ERR_EN
    assign err          = r_err;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req, mem_write, d_data_valid, busy;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        req_1, mem_write_1, d_data_valid_1, busy_1;
    logic [2:0]  funct3_1;
    logic [31:0] addr_1, wdata_1, rdata_1;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        err, err_1, exp_err;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        chk_en   = 1'b0;
    logic        exp_valid, exp_busy;
    logic [31:0] exp_rdata;
    logic [31:0] last_rdata = 32'h0;
    bit   [31:0] mm [DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .d_data_valid(d_data_valid),
`ifdef DMEM_MISALIGN_ERR_EN
        .err(err),
`endif
        .busy(busy));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req_1), .mem_write(mem_write_1), .funct3(funct3_1),
        .addr(addr_1), .wdata(wdata_1), .rdata(rdata_1), .d_data_valid(d_data_valid_1),
`ifdef DMEM_MISALIGN_ERR_EN
        .err(err_1),
`endif
        .busy(busy_1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of the main instance against the expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'b0, d_data_valid}, {31'b0, exp_valid});
            chk("busy",  {31'b0, busy},         {31'b0, exp_busy});
            chk("rdata", rdata,                  exp_rdata);
`ifdef DMEM_MISALIGN_ERR_EN
            chk("err",   {31'b0, err},           {31'b0, exp_err});
`endif
            if (d_data_valid) last_rdata = rdata;
        end
    end

    task automatic set_idle();
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_rdata = 32'h0;
`ifdef DMEM_MISALIGN_ERR_EN
        exp_err   = 1'b0;
`endif
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    function automatic bit mis(input logic [2:0] f3, input bit we, input logic [31:0] a);
        return MIS_EN && (((f3 == 3'd1) && (a % 2 != 0)) || ((f3 == 3'd5) && !we && (a % 2 != 0)) ||
                          ((f3 == 3'd2) && (a % 4 != 0)));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        bit [31:0] w, b, h;
        w = mm[widx(a)];
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit [31:0] w;
        int sh;
        w = mm[widx(a)];
        case (f3)
            3'd0: begin
                sh = 8 * int'(a % 4);
                w  = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end
            3'd1: begin
                sh = 16 * int'((a / 2) % 2);
                w  = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            end
            3'd2:    w = d;
            default: ;
        endcase
        mm[widx(a)] = w;
    endtask

    // One access on the main instance; entered and left at posedge+1 with the DUT idle.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        logic [31:0] er;
        bit e;
        e  = mis(f3, we, a);
        er = (we || e) ? 32'h0 : m_load(f3, a);
        reset = 1'b0; mem_write = we; funct3 = f3; addr = a; wdata = d; req = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            mem_write = $urandom_range(0, 1); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            exp_busy  = 1'b1;
            exp_valid = (k == LAT);
            exp_rdata = (k == LAT) ? er : 32'h0;
`ifdef DMEM_MISALIGN_ERR_EN
            exp_err   = (k == LAT) && e;
`endif
        end
        if (hold == 0) req = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            set_idle();
            exp_busy = 1'b1;
            if (k == hold - 1) req = 1'b0;
        end
        @(posedge clk); #1;
        set_idle();
        if (we && !e) m_store(f3, a, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            set_idle();
        end
    endtask

    // One-cycle request pulse on the LATENCY=1 instance.
    task automatic txn1(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
        mem_write_1 = we; funct3_1 = f3; addr_1 = a; wdata_1 = d; req_1 = 1'b1;
        @(posedge clk); #1;
        req_1 = 1'b0; addr_1 = $urandom; wdata_1 = $urandom;
        @(negedge clk);
        chk({nm, "_valid"}, {30'b0, busy_1, d_data_valid_1}, 32'd3);
        chk({nm, "_rdata"}, rdata_1, exp_rd);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_idle"}, {30'b0, busy_1, d_data_valid_1}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_nodrain"}, {30'b0, busy_1, d_data_valid_1}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
        req_1 = 1'b0; mem_write_1 = 1'b0; funct3_1 = 3'b0; addr_1 = 32'h0; wdata_1 = 32'h0;
        set_idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);

        txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 3);
        txn(0, 3'b000, 32'h13, 32'h0, 0);          chk("lit_lb",  last_rdata, 32'hFFFFFFDE);
        txn(0, 3'b100, 32'h13, 32'h0, 1);          chk("lit_lbu", last_rdata, 32'h000000DE);
        txn(0, 3'b001, 32'h10, 32'h0, 0);          chk("lit_lh",  last_rdata, 32'hFFFFBEEF);
        txn(0, 3'b010, 32'h10, 32'h0, 2);          chk("lit_lw",  last_rdata, 32'hDEADBEEF);
        txn(1, 3'b000, 32'h11, 32'h55, 0);
        txn(0, 3'b010, 32'h10, 32'h0, 0);          chk("lit_sb",  last_rdata, 32'hDEAD55EF);
        txn(0, 3'b010, 32'h10 + 4 * DEPTH, 32'h0, 0); chk("lit_wrap", last_rdata, 32'hDEAD55EF);

        txn(1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        reset = 1'b1; req = 1'b0;
        set_idle();
        idle(2);
        reset = 1'b0;
        idle(2);
        txn(0, 3'b010, 32'h20, 32'h0, 0);          chk("lit_rst_drop", last_rdata, 32'hCAFEF00D);

        txn(1, 3'b010, 32'h22, 32'hFFFFFFFF, 0);
        txn(0, 3'b010, 32'h20, 32'h0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("lit_mis", last_rdata, 32'hCAFEF00D);
`else
        chk("lit_mis", last_rdata, 32'hFFFFFFFF);
`endif

        reset = 1'b1; req = 1'b1; funct3 = 3'b010; addr = 32'h10; mem_write = 1'b0;
        idle(2);
        txn(0, 3'b010, 32'h10, 32'h0, 1);          chk("lit_rst_req", last_rdata, 32'hDEAD55EF);

        for (int i = 0; i < DEPTH; i++)
            txn(1, 3'b010, (32'($urandom_range(0, 255)) * 32'd4 * DEPTH) + 32'(i * 4), $urandom, 0);
        for (int i = 0; i < 300; i++) begin
            txn($urandom_range(0, 1), 3'($urandom), $urandom, $urandom, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        txn1(0, 3'b011, $urandom, 32'h0, 32'h0, "l1_f3_011");
        txn1(1, 3'b010, 32'h8, 32'hA5A51234, 32'h0, "l1_sw");
        txn1(0, 3'b001, 32'h8, 32'h0, 32'h00001234, "l1_lh");
        txn1(0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFA5, "l1_lb");
        txn1(0, 3'b101, 32'hA, 32'h0, 32'h0000A5A5, "l1_lhu");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
